vector_result_writer: RTL and testbench

- Downstream write-back stage for the vector add functional unit (and sibling vector FUs).
- Captures the FU result stream after a fixed functional delay and writes one element per clock into destination vector register Vi, at element addresses 0..VL-1.
- Publishes per-register write progress so the issue logic can chain dependent vector instructions off Vi.

---
 rtl/vector_result_writer_pkg.sv | 26 ++
 rtl/vector_result_writer_if.sv | 31 +++
 rtl/vector_result_writer_delay_counter.sv | 36 +++
 rtl/vector_result_writer.sv | 114 +++++++++++
 tb/tb_vector_result_writer.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/vector_result_writer_pkg.sv
// Shared construction constants for the vector write-back stages: widths, VL limits, FSM encoding.
// Used by vector_result_writer and its sub-modules.
package vector_result_writer_pkg;

   localparam int unsigned WordW = 64;
   localparam int unsigned VlW   = 7;
   localparam int unsigned MaxVl = 64;
   localparam int unsigned SelW  = 3;
   localparam int unsigned AddrW = 6;
   localparam int unsigned DlyW  = 4;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StDelay = 2'd1,
      StWrite = 2'd2
   } vwb_state_e;

   // A VL of 0 means a full register; anything longer than a register is clamped.
   function automatic logic [VlW-1:0] eff_len(input logic [VlW-1:0] vl);
      if (vl == '0 || vl > VlW'(MaxVl)) begin
         return VlW'(MaxVl);
      end
      return vl;
   endfunction

endpackage

// File: rtl/vector_result_writer_if.sv
// Start/result inputs and vector-register write port of the result writer.
// master = issue logic / FU side, slave = the write-back stage.
interface vector_result_writer_if
   import vector_result_writer_pkg::*;
#(
   parameter int unsigned DW = WordW
);

   logic             i_start;
   logic [SelW-1:0]  i_i;
   logic [VlW-1:0]   i_vl;
   logic [DW-1:0]    i_result;
   logic             o_vwr_en;
   logic [SelW-1:0]  o_vwr_sel;
   logic [AddrW-1:0] o_vwr_addr;
   logic [DW-1:0]    o_vwr_data;
   logic             o_busy;
   logic [VlW-1:0]   o_elem_done;
   logic             o_overrun;

   modport master (
      output i_start, i_i, i_vl, i_result,
      input  o_vwr_en, o_vwr_sel, o_vwr_addr, o_vwr_data, o_busy, o_elem_done, o_overrun
   );

   modport slave (
      input  i_start, i_i, i_vl, i_result,
      output o_vwr_en, o_vwr_sel, o_vwr_addr, o_vwr_data, o_busy, o_elem_done, o_overrun
   );

endinterface

// File: rtl/vector_result_writer_delay_counter.sv
// vwb_delay_counter: loadable down-counter that flags the clock on which it reaches zero.
// Shared by FU write-back stages with differing functional delays.
module vwb_delay_counter #(
   parameter int unsigned Width = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   input  logic             dec_i,
   output logic             zero_o
);

   logic [Width-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && count_q != '0) begin
         count_d = count_q - Width'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // High on the decrement that lands on zero, so the owner can change state on that same edge.
   assign zero_o = dec_i && !load_i && (count_q == Width'(1));

endmodule

// File: rtl/vector_result_writer.sv
// Vector FU write-back: waits FU_DELAY clocks after start, then writes L elements into Vi.
// Define CRAY_VWB_CHAIN_EN to publish the element count per write (chaining); otherwise at the end.
module vector_result_writer
   import vector_result_writer_pkg::*;
#(
   parameter int unsigned FU_DELAY = 2,
   parameter int unsigned DW       = WordW
) (
   input logic                   clk,
   input logic                   rst,
   vector_result_writer_if.slave bus
);

   localparam logic [DlyW-1:0] DlyLoad = DlyW'(FU_DELAY - 1);

   vwb_state_e       state_q;
   logic             busy_q;
   logic             overrun_q;
   logic [SelW-1:0]  sel_q;
   logic [VlW-1:0]   len_q;
   logic [VlW-1:0]   elem_q;
   logic             vwr_en_q;
   logic [SelW-1:0]  vwr_sel_q;
   logic [AddrW-1:0] vwr_addr_q;
   logic [DW-1:0]    vwr_data_q;
   logic [VlW-1:0]   elem_done_q;

   logic accept;
   logic dly_dec;
   logic dly_zero;

   // busy_q also covers the cycle the last write is on the port, so a start there is refused.
   assign accept  = bus.i_start && !busy_q;
   assign dly_dec = (state_q == StDelay);

   vwb_delay_counter #(
      .Width (DlyW)
   ) u_delay_counter (
      .clk_i      (clk),
      .rst_ni     (rst),
      .load_i     (accept),
      .load_val_i (DlyLoad),
      .dec_i      (dly_dec),
      .zero_o     (dly_zero)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         sel_q       <= '0;
         len_q       <= '0;
         elem_q      <= '0;
         vwr_en_q    <= 1'b0;
         vwr_sel_q   <= '0;
         vwr_addr_q  <= '0;
         vwr_data_q  <= '0;
         elem_done_q <= '0;
      end else begin
         overrun_q <= bus.i_start && busy_q;
         vwr_en_q  <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  sel_q       <= bus.i_i;
                  len_q       <= eff_len(bus.i_vl);
                  elem_q      <= '0;
                  elem_done_q <= '0;
                  busy_q      <= 1'b1;
                  state_q     <= (FU_DELAY == 1) ? StWrite : StDelay;
               end else begin
                  busy_q <= 1'b0;
`ifndef CRAY_VWB_CHAIN_EN
                  if (vwr_en_q) begin
                     elem_done_q <= len_q;
                  end
`endif
               end
            end
            StDelay: begin
               if (dly_zero) begin
                  state_q <= StWrite;
               end
            end
            StWrite: begin
               vwr_en_q   <= 1'b1;
               vwr_sel_q  <= sel_q;
               vwr_addr_q <= elem_q[AddrW-1:0];
               vwr_data_q <= bus.i_result;
               elem_q     <= elem_q + VlW'(1);
`ifdef CRAY_VWB_CHAIN_EN
               elem_done_q <= elem_q + VlW'(1);
`endif
               if (elem_q == len_q - VlW'(1)) begin
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.o_vwr_en    = vwr_en_q;
   assign bus.o_vwr_sel   = vwr_sel_q;
   assign bus.o_vwr_addr  = vwr_addr_q;
   assign bus.o_vwr_data  = vwr_data_q;
   assign bus.o_busy      = busy_q | bus.i_start;
   assign bus.o_elem_done = elem_done_q;
   assign bus.o_overrun   = overrun_q;

endmodule

// File: tb/tb_vector_result_writer.sv
// Self-checking bench for vector_result_writer: random results and lengths against a cycle-offset model.
// Offsets count clocks from the start cycle; element k is expected at offset D+1+k.
module tb_vector_result_writer;

   localparam int D = 2;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   vl_tab[6] = '{4, 0, 1, 100, 64, 5};

   vector_result_writer_if #(.DW(64)) vif ();

   vector_result_writer #(
      .FU_DELAY (D),
      .DW       (64)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (vif)
   );

   always #5 clk = ~clk;

   function automatic int exp_len(input int vl);
      return (vl == 0 || vl > 64) ? 64 : vl;
   endfunction

   // Elements already visible on the write port at offset c.
   function automatic int written(input int c, input int len);
      int w;
      w = c - D;
      if (w < 0) w = 0;
      if (w > len) w = len;
      return w;
   endfunction

   function automatic int exp_done(input int c, input int len);
`ifdef CRAY_VWB_CHAIN_EN
      return written(c, len);
`else
      return (c > D + len) ? len : 0;
`endif
   endfunction

   function automatic logic [63:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++; if (vif.o_vwr_en !== 1'b0) begin errors++; $display("FAIL rst_en got %0b want 0", vif.o_vwr_en); end
      checks++; if (vif.o_vwr_sel !== 3'd0) begin errors++; $display("FAIL rst_sel got %0d want 0", vif.o_vwr_sel); end
      checks++; if (vif.o_vwr_addr !== 6'd0) begin errors++; $display("FAIL rst_addr got %0d want 0", vif.o_vwr_addr); end
      checks++; if (vif.o_vwr_data !== 64'd0) begin errors++; $display("FAIL rst_data got %h want 0", vif.o_vwr_data); end
      checks++; if (vif.o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0b want 0", vif.o_busy); end
      checks++; if (vif.o_elem_done !== 7'd0) begin errors++; $display("FAIL rst_done got %0d want 0", vif.o_elem_done); end
      checks++; if (vif.o_overrun !== 1'b0) begin errors++; $display("FAIL rst_ovr got %0b want 0", vif.o_overrun); end
      rst = 1'b1;
   endtask

   // Single operations over fixed VL boundaries plus random lengths; checks timing, data and chain count.
   task automatic test_write_back();
      logic [63:0] res[$];
      logic [2:0]  sel;
      int          vl, len, k;
      bit          exp_en;
      for (int n = 0; n < 9; n++) begin
         vl  = (n < 6) ? vl_tab[n] : int'($urandom_range(0, 127));
         sel = 3'($urandom_range(0, 7));
         len = exp_len(vl);
         tick();
         res.delete();
         vif.i_start  = 1'b1;
         vif.i_i      = sel;
         vif.i_vl     = 7'(vl);
         vif.i_result = rnd64();
         res.push_back(vif.i_result);
         #1;
         checks++; if (vif.o_busy !== 1'b1) begin errors++; $display("FAIL wb_busy_start op%0d got %0b want 1", n, vif.o_busy); end
         for (int c = 1; c <= D + len + 2; c++) begin
            tick();
            vif.i_start  = 1'b0;
            vif.i_result = rnd64();
            res.push_back(vif.i_result);
            #1;
            exp_en = (c >= D + 1) && (c <= D + len);
            checks++; if (vif.o_vwr_en !== exp_en) begin errors++; $display("FAIL wb_en op%0d vl%0d c%0d got %0b want %0b", n, vl, c, vif.o_vwr_en, exp_en); end
            checks++; if (vif.o_busy !== (c <= D + len)) begin errors++; $display("FAIL wb_busy op%0d c%0d got %0b want %0b", n, c, vif.o_busy, (c <= D + len)); end
            checks++; if (vif.o_elem_done !== 7'(exp_done(c, len))) begin errors++; $display("FAIL wb_done op%0d c%0d got %0d want %0d", n, c, vif.o_elem_done, exp_done(c, len)); end
            checks++; if (vif.o_overrun !== 1'b0) begin errors++; $display("FAIL wb_ovr op%0d c%0d got %0b want 0", n, c, vif.o_overrun); end
            if (exp_en) begin
               k = c - D - 1;
               checks++; if (vif.o_vwr_addr !== 6'(k)) begin errors++; $display("FAIL wb_addr op%0d c%0d got %0d want %0d", n, c, vif.o_vwr_addr, k); end
               checks++; if (vif.o_vwr_sel !== sel) begin errors++; $display("FAIL wb_sel op%0d c%0d got %0d want %0d", n, c, vif.o_vwr_sel, sel); end
               checks++; if (vif.o_vwr_data !== res[c-1]) begin errors++; $display("FAIL wb_data op%0d k%0d got %h want %h", n, k, vif.o_vwr_data, res[c-1]); end
            end
         end
      end
   endtask

   // Second start during the operation, then a start on the cycle of the final write.
   task automatic test_overrun();
      logic [63:0] res[$];
      logic [2:0]  sel;
      int          len, ov_off, ov_cnt, en_cnt;
      bit          exp_en;
      for (int p = 0; p < 2; p++) begin
         len    = (p == 0) ? 8 : int'($urandom_range(2, 10));
         ov_off = (p == 0) ? 3 : D + len;
         sel    = 3'($urandom_range(0, 7));
         ov_cnt = 0;
         en_cnt = 0;
         tick();
         res.delete();
         vif.i_start  = 1'b1;
         vif.i_i      = sel;
         vif.i_vl     = 7'(len);
         vif.i_result = rnd64();
         res.push_back(vif.i_result);
         for (int c = 1; c <= D + len + 6; c++) begin
            tick();
            vif.i_start  = (c == ov_off);
            vif.i_i      = ~sel;
            vif.i_vl     = 7'($urandom_range(1, 64));
            vif.i_result = rnd64();
            res.push_back(vif.i_result);
            #1;
            exp_en = (c >= D + 1) && (c <= D + len);
            if (vif.o_overrun === 1'b1) ov_cnt++;
            if (vif.o_vwr_en === 1'b1) en_cnt++;
            checks++; if (vif.o_vwr_en !== exp_en) begin errors++; $display("FAIL ovr_en ph%0d c%0d got %0b want %0b", p, c, vif.o_vwr_en, exp_en); end
            if (exp_en) begin
               checks++; if (vif.o_vwr_sel !== sel || vif.o_vwr_addr !== 6'(c - D - 1) || vif.o_vwr_data !== res[c-1]) begin
                  errors++; $display("FAIL ovr_write ph%0d c%0d got sel%0d addr%0d %h want sel%0d addr%0d %h", p, c, vif.o_vwr_sel, vif.o_vwr_addr, vif.o_vwr_data, sel, c - D - 1, res[c-1]);
               end
            end
         end
         checks++; if (ov_cnt !== 1) begin errors++; $display("FAIL ovr_pulses ph%0d got %0d want 1", p, ov_cnt); end
         checks++; if (en_cnt !== len) begin errors++; $display("FAIL ovr_writes ph%0d got %0d want %0d", p, en_cnt, len); end
         checks++; if (vif.o_busy !== 1'b0) begin errors++; $display("FAIL ovr_busy_end ph%0d got %0b want 0", p, vif.o_busy); end
      end
   endtask

   // Asynchronous reset after two of six writes, then a fresh operation from address 0.
   task automatic test_reset_mid();
      logic [63:0] res[$];
      int          len;
      bit          exp_en;
      tick();
      vif.i_start  = 1'b1;
      vif.i_i      = 3'd5;
      vif.i_vl     = 7'd6;
      vif.i_result = rnd64();
      for (int c = 1; c <= D + 2; c++) begin
         tick();
         vif.i_start  = 1'b0;
         vif.i_result = rnd64();
      end
      #1;
      checks++; if (vif.o_vwr_en !== 1'b1 || vif.o_vwr_addr !== 6'd1) begin errors++; $display("FAIL rm_pre got en%0b addr%0d want en1 addr1", vif.o_vwr_en, vif.o_vwr_addr); end
      rst = 1'b0;
      #1;
      checks++; if (vif.o_vwr_en !== 1'b0) begin errors++; $display("FAIL rm_en got %0b want 0", vif.o_vwr_en); end
      checks++; if (vif.o_busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %0b want 0", vif.o_busy); end
      checks++; if (vif.o_elem_done !== 7'd0) begin errors++; $display("FAIL rm_done got %0d want 0", vif.o_elem_done); end
      checks++; if (vif.o_vwr_addr !== 6'd0 || vif.o_vwr_sel !== 3'd0 || vif.o_vwr_data !== 64'd0) begin
         errors++; $display("FAIL rm_port got addr%0d sel%0d %h want all 0", vif.o_vwr_addr, vif.o_vwr_sel, vif.o_vwr_data);
      end
      for (int c = 0; c < 2; c++) begin
         tick();
         checks++; if (vif.o_vwr_en !== 1'b0) begin errors++; $display("FAIL rm_hold c%0d got %0b want 0", c, vif.o_vwr_en); end
      end
      rst = 1'b1;
      len = 3;
      res.delete();
      vif.i_start  = 1'b1;
      vif.i_i      = 3'd2;
      vif.i_vl     = 7'(len);
      vif.i_result = rnd64();
      res.push_back(vif.i_result);
      for (int c = 1; c <= D + len + 1; c++) begin
         tick();
         vif.i_start  = 1'b0;
         vif.i_result = rnd64();
         res.push_back(vif.i_result);
         #1;
         exp_en = (c >= D + 1) && (c <= D + len);
         checks++; if (vif.o_vwr_en !== exp_en) begin errors++; $display("FAIL rm_new_en c%0d got %0b want %0b", c, vif.o_vwr_en, exp_en); end
         if (exp_en) begin
            checks++; if (vif.o_vwr_addr !== 6'(c - D - 1) || vif.o_vwr_data !== res[c-1]) begin
               errors++; $display("FAIL rm_new_write c%0d got addr%0d %h want addr%0d %h", c, vif.o_vwr_addr, vif.o_vwr_data, c - D - 1, res[c-1]);
            end
         end
      end
   endtask

   // Each start lands on the first cycle o_busy is low and must be accepted without overrun.
   task automatic test_back_to_back();
      logic [63:0] res[$];
      logic [2:0]  sel;
      int          len;
      bit          exp_en;
      tick();
      for (int n = 0; n < 4; n++) begin
         len = int'($urandom_range(1, 6));
         sel = 3'($urandom_range(0, 7));
         res.delete();
         vif.i_start  = 1'b1;
         vif.i_i      = sel;
         vif.i_vl     = 7'(len);
         vif.i_result = rnd64();
         res.push_back(vif.i_result);
         #1;
         checks++; if (vif.o_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_start op%0d got %0b want 1", n, vif.o_busy); end
         for (int c = 1; c <= D + len + 1; c++) begin
            tick();
            vif.i_start  = 1'b0;
            vif.i_result = rnd64();
            res.push_back(vif.i_result);
            #1;
            exp_en = (c >= D + 1) && (c <= D + len);
            checks++; if (vif.o_vwr_en !== exp_en) begin errors++; $display("FAIL b2b_en op%0d c%0d got %0b want %0b", n, c, vif.o_vwr_en, exp_en); end
            checks++; if (vif.o_overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr op%0d c%0d got %0b want 0", n, c, vif.o_overrun); end
            if (exp_en) begin
               checks++; if (vif.o_vwr_sel !== sel || vif.o_vwr_addr !== 6'(c - D - 1) || vif.o_vwr_data !== res[c-1]) begin
                  errors++; $display("FAIL b2b_write op%0d c%0d got sel%0d addr%0d %h want sel%0d addr%0d %h", n, c, vif.o_vwr_sel, vif.o_vwr_addr, vif.o_vwr_data, sel, c - D - 1, res[c-1]);
               end
            end
         end
         checks++; if (vif.o_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_end op%0d got %0b want 0", n, vif.o_busy); end
      end
      vif.i_start = 1'b0;
   endtask

   initial begin
      vif.i_start  = 1'b0;
      vif.i_i      = 3'd0;
      vif.i_vl     = 7'd0;
      vif.i_result = 64'd0;
      test_reset();
      test_write_back();
      test_overrun();
      test_reset_mid();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
